// File: rtl/result_display_ctrl.sv
// Result banner sequencer: latches a round outcome, blinks it, holds it, then clears it.
// The display state only changes on frame_start so the overlay never tears mid-frame.
module result_display_ctrl #(
  parameter int BLINK_FRAMES  = 15,
  parameter int BLINK_TOGGLES = 6,
  parameter int HOLD_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       result_valid,
  input  logic [1:0] result_code,
  input  logic       ack,
  output logic [2:0] state,
  output logic       busy,
  output logic       done
);

  localparam int FMAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
  localparam int FCW  = $clog2(FMAX + 1);
  localparam int TCW  = $clog2(BLINK_TOGGLES + 1);

  localparam logic [FCW-1:0] BLINK_LIM = FCW'(BLINK_FRAMES);
  localparam logic [FCW-1:0] HOLD_LIM  = FCW'(HOLD_FRAMES);
  localparam logic [TCW-1:0] TOG_LIM   = TCW'(BLINK_TOGGLES);
  localparam logic [FCW-1:0] F_ONE     = FCW'(1);
  localparam logic [TCW-1:0] T_ONE     = TCW'(1);

  typedef enum logic [1:0] {IDLE, BLINK, HOLD, CLEAR} fsm_t;

  fsm_t           fsm_q;
  logic           vis_q;
  logic [1:0]     code_q;
  logic [FCW-1:0] frame_cnt_q;
  logic [TCW-1:0] toggle_cnt_q;
  logic [2:0]     state_q;
  logic           busy_q;
  logic           done_q;

  logic [FCW-1:0] frame_cnt_d;
  logic [TCW-1:0] toggle_cnt_d;
  logic [2:0]     code_map_d;

  assign frame_cnt_d  = frame_cnt_q + F_ONE;
  assign toggle_cnt_d = toggle_cnt_q + T_ONE;
  assign code_map_d   = {1'b0, code_q} + 3'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      vis_q        <= 1'b0;
      code_q       <= 2'd0;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      state_q      <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Display register samples the visibility from before this cycle's update.
      if (frame_start) begin
        state_q <= vis_q ? code_map_d : 3'd0;
      end

      case (fsm_q)
        IDLE: begin
          vis_q <= 1'b0;
          if (result_valid && (result_code != 2'd0)) begin
            code_q       <= result_code;
            vis_q        <= 1'b1;
            frame_cnt_q  <= '0;
            toggle_cnt_q <= '0;
            busy_q       <= 1'b1;
            fsm_q        <= BLINK;
          end
        end
        BLINK: begin
          if (ack) begin
            vis_q <= 1'b0;
            fsm_q <= CLEAR;
          end else if (frame_start) begin
            if (frame_cnt_d == BLINK_LIM) begin
              frame_cnt_q  <= '0;
              toggle_cnt_q <= toggle_cnt_d;
              if (toggle_cnt_d == TOG_LIM) begin
                vis_q <= 1'b1;
                fsm_q <= HOLD;
              end else begin
                vis_q <= ~vis_q;
              end
            end else begin
              frame_cnt_q <= frame_cnt_d;
            end
          end
        end
        HOLD: begin
          vis_q <= 1'b1;
          if (ack) begin
            vis_q <= 1'b0;
            fsm_q <= CLEAR;
          end else if (frame_start) begin
            if (frame_cnt_d == HOLD_LIM) begin
              vis_q <= 1'b0;
              fsm_q <= CLEAR;
            end else begin
              frame_cnt_q <= frame_cnt_d;
            end
          end
        end
        CLEAR: begin
          vis_q <= 1'b0;
          if (frame_start) begin
            code_q       <= 2'd0;
            frame_cnt_q  <= '0;
            toggle_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            fsm_q        <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Scenario bench for result_display_ctrl with short blink/hold parameters and 20-cycle frames.
module tb_result_display_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       result_valid = 1'b0;
  logic [1:0] result_code = 2'd0;
  logic       ack = 1'b0;
  logic [2:0] state;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [2:0] exp_q[$];

  result_display_ctrl #(
    .BLINK_FRAMES(2),
    .BLINK_TOGGLES(4),
    .HOLD_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .result_valid(result_valid),
    .result_code(result_code),
    .ack(ack),
    .state(state),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame pulse, optionally with a coincident result_valid and/or ack; returns 1 time unit after the edge.
  task automatic frame(input bit with_rv, input logic [1:0] rv_code, input bit with_ack);
    idle_cycles(19);
    frame_start  = 1'b1;
    result_valid = with_rv;
    result_code  = rv_code;
    ack          = with_ack;
    @(posedge clk);
    #1;
    frame_start  = 1'b0;
    result_valid = 1'b0;
    ack          = 1'b0;
  endtask

  task automatic pulse_rv(input logic [1:0] code);
    idle_cycles(3);
    result_valid = 1'b1;
    result_code  = code;
    @(posedge clk);
    #1;
    result_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    idle_cycles(5);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  function automatic logic [2:0] pop_exp();
    if (exp_q.size() == 0) return 3'd7;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", state); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_full_sequence(input logic [1:0] code);
    logic [2:0] c;
    logic [2:0] e;
    int d0;
    c  = {1'b0, code} + 3'd2;
    d0 = done_cnt;
    pulse_rv(code);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy_after_accept got=%b want=1", busy); end
    exp_q.push_back(c);    exp_q.push_back(c);    exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(c);    exp_q.push_back(c);    exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(c);    exp_q.push_back(c);    exp_q.push_back(c);    exp_q.push_back(3'd0);
    for (int i = 0; i < 12; i++) begin
      frame(1'b0, 2'd0, 1'b0);
      e = pop_exp();
      n_checks++;
      if (state !== e) begin n_fail++; $display("FAIL seq_frame%0d got=%0d want=%0d", i + 1, state, e); end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL seq_done_with_f12 got=%b want=1", done); end
    idle_cycles(3);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy_after got=%b want=0", busy); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL seq_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_ack_abort();
    logic [2:0] e;
    int d0;
    d0 = done_cnt;
    pulse_rv(2'd2);
    exp_q.push_back(3'd4); exp_q.push_back(3'd4); exp_q.push_back(3'd0);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) pulse_ack();
      // A second outcome arrives at F2 and must be ignored.
      frame(i == 1, 2'd3, 1'b0);
      e = pop_exp();
      n_checks++;
      if (state !== e) begin n_fail++; $display("FAIL ack_frame%0d got=%0d want=%0d", i + 1, state, e); end
      if (i == 3) begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ack_done_after_f4 got=%b want=1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ack_busy_after_f4 got=%b want=0", busy); end
      end
    end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL ack_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_invalid_code();
    logic [2:0] e;
    int d0;
    d0 = done_cnt;
    pulse_rv(2'd0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL inv_busy got=%b want=0", busy); end
    for (int i = 0; i < 5; i++) exp_q.push_back(3'd0);
    for (int i = 0; i < 5; i++) begin
      frame(1'b0, 2'd0, 1'b0);
      e = pop_exp();
      n_checks++;
      if (state !== e || busy !== 1'b0) begin
        n_fail++; $display("FAIL inv_frame%0d state=%0d busy=%b want state=%0d busy=0", i + 1, state, busy, e);
      end
    end
    // Acknowledge while idle must not start anything.
    pulse_ack();
    idle_cycles(2);
    n_checks++; if (busy !== 1'b0 || done_cnt != d0) begin n_fail++; $display("FAIL idle_ack busy=%b dones=%0d want busy=0 dones=0", busy, done_cnt - d0); end
  endtask

  task automatic test_coincident_accept();
    logic [2:0] e;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd5); exp_q.push_back(3'd5); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd5); exp_q.push_back(3'd5); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd5); exp_q.push_back(3'd5); exp_q.push_back(3'd5); exp_q.push_back(3'd0);
    frame(1'b1, 2'd3, 1'b0);
    e = pop_exp();
    n_checks++; if (state !== e) begin n_fail++; $display("FAIL coin_first got=%0d want=%0d", state, e); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL coin_busy got=%b want=1", busy); end
    for (int i = 0; i < 12; i++) begin
      frame(1'b0, 2'd0, 1'b0);
      e = pop_exp();
      n_checks++;
      if (state !== e) begin n_fail++; $display("FAIL coin_frame%0d got=%0d want=%0d", i + 2, state, e); end
    end
    idle_cycles(2);
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL coin_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_hold();
    logic [2:0] e;
    exp_q.push_back(3'd4); exp_q.push_back(3'd4); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd4); exp_q.push_back(3'd4); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd4);
    pulse_rv(2'd2);
    for (int i = 0; i < 9; i++) begin
      frame(1'b0, 2'd0, 1'b0);
      e = pop_exp();
      n_checks++;
      if (state !== e) begin n_fail++; $display("FAIL rsth_frame%0d got=%0d want=%0d", i + 1, state, e); end
    end
    idle_cycles(4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rsth_after state=%0d busy=%b done=%b want 0/0/0", state, busy, done);
    end
    test_full_sequence(2'd1);
  endtask

  task automatic test_ack_terminal();
    logic [2:0] e;
    int d0;
    d0 = done_cnt;
    pulse_rv(2'd1);
    exp_q.push_back(3'd3); exp_q.push_back(3'd3); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd3); exp_q.push_back(3'd3); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd3); exp_q.push_back(3'd3); exp_q.push_back(3'd3); exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    for (int i = 0; i < 13; i++) begin
      frame(1'b0, 2'd0, i == 10);
      e = pop_exp();
      n_checks++;
      if (state !== e) begin n_fail++; $display("FAIL term_frame%0d got=%0d want=%0d", i + 1, state, e); end
      if (i == 11) begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL term_done_f12 got=%b want=1", done); end
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL term_busy got=%b want=0", busy); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL term_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_full_sequence(2'd1);
    test_ack_abort();
    test_invalid_code();
    test_coincident_accept();
    test_reset_mid_hold();
    test_ack_terminal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
